// File: rtl/rle_encoder_if.sv
// rtl/rle_encoder_if.sv - element input stream and {count,value} output stream of the run-length encoder
interface rle_encoder_if #(
  parameter int ELEM_W = 32,
  parameter int CNT_W  = 32
);
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic [ELEM_W-1:0]       s_axis_tdata;
  logic                    s_axis_tlast;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic [CNT_W+ELEM_W-1:0] m_axis_tdata;
  logic                    m_axis_tlast;

  // encoder side
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  // host / neighbouring stage side
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/rle_encoder.sv
// rtl/rle_encoder.sv - word-level run-length encoder, one {count,value} pair per run, runs confined to a packet
module rle_encoder #(
  parameter int ELEM_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  rle_encoder_if.slave bus,
  output logic [31:0] pkt_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state;
  state_t              next_state;
  logic [ELEM_W-1:0]   run_val;
  logic [CNT_W-1:0]    run_cnt;
  logic [ELEM_W-1:0]   pend_val;

  logic                free;
  logic                accept;
  logic                extend;
  logic                load;
  logic [CNT_W-1:0]    load_cnt;
  logic [ELEM_W-1:0]   load_val;
  logic                load_last;
  logic                open_run;
  logic                inc_run;
  logic                set_pend;

  assign free              = !bus.m_axis_tvalid || bus.m_axis_tready;
  assign bus.s_axis_tready = free && (state != FLUSH);
  assign accept            = bus.s_axis_tvalid && bus.s_axis_tready;
  // a beat may join the open run only on an exact match with headroom left in the counter
  assign extend            = (bus.s_axis_tdata == run_val) && (run_cnt != CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept && !bus.s_axis_tlast) next_state = RUN;
      RUN:     if (accept && bus.s_axis_tlast) next_state = extend ? IDLE : FLUSH;
      FLUSH:   if (free) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    load_cnt  = '0;
    load_val  = '0;
    load_last = 1'b0;
    open_run  = 1'b0;
    inc_run   = 1'b0;
    set_pend  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bus.s_axis_tlast) begin
            load      = 1'b1;
            load_cnt  = CNT_ONE;
            load_val  = bus.s_axis_tdata;
            load_last = 1'b1;
          end else begin
            open_run  = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (extend) begin
            if (bus.s_axis_tlast) begin
              load      = 1'b1;
              load_cnt  = run_cnt + CNT_ONE;
              load_val  = run_val;
              load_last = 1'b1;
            end else begin
              inc_run   = 1'b1;
            end
          end else begin
            // closing pair goes out now; a last beat becomes its own pair from FLUSH
            load     = 1'b1;
            load_cnt = run_cnt;
            load_val = run_val;
            set_pend = bus.s_axis_tlast;
            open_run = !bus.s_axis_tlast;
          end
        end
      end
      FLUSH: begin
        if (free) begin
          load      = 1'b1;
          load_cnt  = CNT_ONE;
          load_val  = pend_val;
          load_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_val  <= '0;
      run_cnt  <= '0;
      pend_val <= '0;
    end else begin
      if (open_run) begin
        run_val <= bus.s_axis_tdata;
        run_cnt <= CNT_ONE;
      end else if (inc_run) begin
        run_cnt <= run_cnt + CNT_ONE;
      end
      if (set_pend) begin
        pend_val <= bus.s_axis_tdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tlast  <= 1'b0;
    end else if (load) begin
      bus.m_axis_tvalid <= 1'b1;
      bus.m_axis_tdata  <= {load_cnt, load_val};
      bus.m_axis_tlast  <= load_last;
    end else if (bus.m_axis_tready) begin
      bus.m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_rle_encoder.sv
// tb/tb_rle_encoder.sv - directed table-driven bench for rle_encoder with ELEM_W=16, CNT_W=4
module tb_rle_encoder;

  localparam int EW = 16;
  localparam int CW = 4;

  localparam logic [15:0] VA = 16'h00AA;
  localparam logic [15:0] VB = 16'h00BB;
  localparam logic [15:0] VC = 16'h0C0C;
  localparam logic [15:0] VD = 16'h00DD;
  localparam logic [15:0] VE = 16'h0EEE;
  localparam logic [15:0] VF = 16'h00F1;
  localparam logic [15:0] VG = 16'h0777;
  localparam logic [15:0] VX = 16'h1234;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        mr;
    logic        sr;
    logic        mv;
    logic [19:0] md;
    logic        ml;
    logic [31:0] pkt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pkt_count;
  int          total = 0;
  int          bad = 0;
  vec_t        vecs[$];

  rle_encoder_if #(.ELEM_W(EW), .CNT_W(CW)) bus ();

  rle_encoder #(.ELEM_W(EW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [15:0] d, input logic l, input logic mr,
                     input logic sr, input logic mv, input logic [3:0] cnt, input logic [15:0] val,
                     input logic ml, input logic [31:0] pkt);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.mr = mr;
    r.sr = sr; r.mv = mv; r.md = {cnt, val}; r.ml = ml; r.pkt = pkt;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic mr);
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.m_axis_tready = mr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 16'h0, 1'b0, 1'b1);

    // A,A,A,B(last): one FLUSH stall cycle
    add(1, VA, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, VA, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, VA, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, VB, 1, 1, 1, 1, 3, VA, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, VB, 1, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    // single-beat packet
    add(1, VX, 1, 1, 1, 1, 1, VX, 1, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 2);
    // equal single-beat packets back to back must not merge
    add(1, VA, 1, 1, 1, 1, 1, VA, 1, 2);
    add(1, VA, 1, 1, 1, 1, 1, VA, 1, 3);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 4);
    // 20 x C with MAX=15
    for (int k = 0; k < 15; k++) add(1, VC, 0, 1, 1, 0, 0, 0, 0, 4);
    add(1, VC, 0, 1, 1, 1, 15, VC, 0, 4);
    for (int k = 0; k < 3; k++) add(1, VC, 0, 1, 1, 0, 0, 0, 0, 4);
    add(1, VC, 1, 1, 1, 1, 5, VC, 1, 4);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 5);
    // backpressure: m_axis_tready low for 10 cycles while feeding A,B,C,D(last)
    add(1, VA, 0, 0, 1, 0, 0, 0, 0, 5);
    add(1, VB, 0, 0, 1, 1, 1, VA, 0, 5);
    for (int k = 0; k < 8; k++) add(1, VC, 0, 0, 0, 1, 1, VA, 0, 5);
    add(1, VC, 0, 1, 1, 1, 1, VB, 0, 5);
    add(1, VD, 1, 1, 1, 1, 1, VC, 0, 5);
    add(0, 0, 0, 1, 0, 1, 1, VD, 1, 5);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 6);

    #23;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mvalid", {31'b0, bus.m_axis_tvalid}, 32'd0);
    chk("rst_mdata",  {12'b0, bus.m_axis_tdata}, 32'd0);
    chk("rst_mlast",  {31'b0, bus.m_axis_tlast}, 32'd0);
    chk("rst_pkt",    pkt_count, 32'd0);
    chk("rst_sready", {31'b0, bus.s_axis_tready}, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].mr);
      #1;
      chk($sformatf("v%0d_sready", i), {31'b0, bus.s_axis_tready}, {31'b0, vecs[i].sr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_mvalid", i), {31'b0, bus.m_axis_tvalid}, {31'b0, vecs[i].mv});
      if (vecs[i].mv) begin
        chk($sformatf("v%0d_mdata", i), {12'b0, bus.m_axis_tdata}, {12'b0, vecs[i].md});
        chk($sformatf("v%0d_mlast", i), {31'b0, bus.m_axis_tlast}, {31'b0, vecs[i].ml});
      end
      chk($sformatf("v%0d_pkt", i), pkt_count, vecs[i].pkt);
    end

    // reset mid-run with a pair parked in the output slot
    drive(1, VE, 0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    drive(1, VG, 0, 0);
    @(posedge clk);
    #1;
    chk("mid_slot_valid", {31'b0, bus.m_axis_tvalid}, 32'd1);
    chk("mid_slot_data",  {12'b0, bus.m_axis_tdata}, {12'b0, 4'd3, VE});
    drive(0, 16'h0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mvalid", {31'b0, bus.m_axis_tvalid}, 32'd0);
    chk("async_pkt",    pkt_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_sready", {31'b0, bus.s_axis_tready}, 32'd1);
    chk("post_rst_mvalid", {31'b0, bus.m_axis_tvalid}, 32'd0);
    drive(1, VF, 1, 1);
    @(posedge clk);
    #1;
    chk("f_mvalid", {31'b0, bus.m_axis_tvalid}, 32'd1);
    chk("f_mdata",  {12'b0, bus.m_axis_tdata}, {12'b0, 4'd1, VF});
    chk("f_mlast",  {31'b0, bus.m_axis_tlast}, 32'd1);
    drive(0, 16'h0, 0, 1);
    @(posedge clk);
    #1;
    chk("f_done_mvalid", {31'b0, bus.m_axis_tvalid}, 32'd0);
    chk("f_done_pkt",    pkt_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rle_encoder.md
# rle_encoder

Word-level run-length encoder for the host data path. It sits directly downstream of the host receive stream and feeds the next user-logic stage or the host send stream. Each packet of ELEM_W-bit elements becomes a packet of {count, value} pairs. Runs never span packet boundaries.

## Interface
Parameters:
- ELEM_W, 32, element width in bits; one element per input beat.
- CNT_W, 32, run-count width. MAX = 2^CNT_W − 1.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when tvalid && tready.
- s_axis_tdata  in  ELEM_W  element.
- s_axis_tlast  in  1  last element of packet.
- m_axis_tvalid  out  1  output pair valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  CNT_W+ELEM_W  {count[CNT_W-1:0] upper, value[ELEM_W-1:0] lower}.
- m_axis_tlast  out  1  last pair of packet.
- pkt_count  out  32  packets fully emitted (output tlast handshakes); wraps 2^32−1 → 0.

## Operation
- Registers:
  - state ∈ {IDLE, RUN, FLUSH};
  - run_val, run_cnt for the open run;
  - one output slot (m_axis_tvalid/tdata/tlast);
  - pend_val for the FLUSH pair.
- Slot free this cycle: free = !m_axis_tvalid || m_axis_tready.
- s_axis_tready = free && (state != FLUSH). This is combinational from m_axis_tready; no combinational path from s_axis_tvalid.
- Accepted beat d with last flag L:
  - IDLE, L=0: open run (run_val=d, run_cnt=1) → RUN.
  - IDLE, L=1: load slot {1,d}, tlast=1 → IDLE.
  - RUN, d==run_val, run_cnt<MAX, L=0: run_cnt+1; no output.
  - RUN, d==run_val, run_cnt<MAX, L=1: load slot {run_cnt+1, run_val}, tlast=1 → IDLE.
  - RUN, close case (d!=run_val or run_cnt==MAX), L=0: load slot {run_cnt, run_val}, tlast=0; open run (d,1); stay RUN.
  - RUN, close case, L=1: load slot {run_cnt, run_val}, tlast=0; pend_val=d → FLUSH.
- FLUSH: on the first cycle with free=1, load slot {1, pend_val}, tlast=1 → IDLE.
- Slot handling:
  - The slot clears when handshaken and not reloaded in the same cycle.
  - A reload in the handshake cycle is legal; there are no bubbles.
- count is never 0 and never exceeds MAX.
- Element comparison is a full ELEM_W-bit equality.
- Runs do not merge across packets even when the values are equal.

## Timing
- Reset (async assert, sync release):
  - state=IDLE; m_axis_tvalid=0; m_axis_tdata=0; m_axis_tlast=0; pkt_count=0; run_cnt=0.
  - s_axis_tready=1 from the first cycle after release.
- Reset mid-packet: any open run and pending pair are discarded. The output drops tvalid immediately (asynchronous).
- Latency:
  - A pair appears on m_axis one cycle after the accept of the beat that closes its run.
  - The FLUSH pair appears one cycle after the closing pair is handshaken, or in the cycle after entry if the slot was already free.
- FLUSH costs exactly one input stall cycle when m_axis_tready=1 continuously.
- Throughput: one input beat per cycle when no FLUSH is entered and the output is never stalled.
- AXI rules:
  - m_axis_tvalid, tdata and tlast are held stable while tvalid && !tready.
  - tvalid never drops without a handshake (except on reset).
- pkt_count updates in the cycle after the tlast handshake.

## Test plan
1. Input A,A,A,B(last), m_axis_tready=1 → outputs {3,A} tlast=0, then {1,B} tlast=1. s_axis_tready is low for exactly one cycle (FLUSH). pkt_count=1.
2. Single beat X with tlast → one output {1,X} tlast=1, one cycle after accept. No stall.
3. CNT_W=4 (MAX=15): 20 beats of C, tlast on the 20th → {15,C} tlast=0, then {5,C} tlast=1.
4. Backpressure: m_axis_tready=0 for 10 cycles while feeding A,B,C,D(last).
   - s_axis_tready falls once the slot holds {1,A}, and stays low until the slot is handshaken.
   - Final outputs are {1,A},{1,B},{1,C},{1,D last}, in order with no loss.
   - tdata is stable during the stall.
5. Reset mid-run: after accepting E,E,E, pulse rst_n low → m_axis_tvalid=0 at once and pkt_count=0. Then F(last) → only {1,F} tlast=1.
6. Packet boundary: A(last), A(last) back-to-back → two separate {1,A} tlast=1 pairs, no merge. pkt_count=2.
